button_click_decoder: RTL and testbench

Front-panel input stage for the De0 Nano SDRAM test harness. It synchronises and debounces the raw KEY push-button and classifies each gesture as a single click or a double click. Classification is decided by a fixed window after the first press. The two level outputs feed the SDRAM host-interface block as its write-request and read-request strobes. That block resets this one through rst_n when the SDRAM controller goes busy.

---
 rtl/button_pkg.sv | 25 ++
 rtl/button_click_decoder_if.sv | 9 +
 rtl/button_debouncer.sv | 60 ++++++
 rtl/button_click_decoder.sv | 80 ++++++++
 tb/tb_button_click_decoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared constants for the front-panel button path: FSM encoding and default
// widths so the host-interface block can size its own timers from WAIT_WIDTH.
package button_pkg;

   localparam int WAIT_WIDTH_DEFAULT     = 19;
   localparam int DEBOUNCE_WIDTH_DEFAULT = 10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_SINGLE = 2'd2;
   localparam logic [1:0] ST_DOUBLE = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      WAIT   = ST_WAIT,
      SINGLE = ST_SINGLE,
      DOUBLE = ST_DOUBLE
   } click_state_t;

   // Number of clk cycles in the double-click window for a given counter width.
   function automatic int window_cycles(input int wait_width);
      return 1 << wait_width;
   endfunction

endpackage

// File: rtl/button_click_decoder_if.sv
// Panel-side signal bundle: raw button in, classified click levels out.
interface button_click_decoder_if;
   logic button;
   logic single;
   logic double;

   modport master (output button, input single, input double);
   modport slave  (input button, output single, output double);
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stability-counter debouncer and rising-edge press pulse.
module button_debouncer
   import button_pkg::*;
#(
   parameter int DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_in,
   output logic level_out,
   output logic press_out
);

   logic [1:0]                sync_reg;
   logic                      btn_s;
   logic                      btn_db_reg;
   logic                      btn_db_next;
   logic                      btn_db_q_reg;
   logic [DEBOUNCE_WIDTH-1:0] cnt_db_reg;
   logic [DEBOUNCE_WIDTH-1:0] cnt_db_next;

   assign btn_s = sync_reg[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_reg <= 2'b00;
      end else begin
         sync_reg <= {sync_reg[0], button_in};
      end
   end

   // The level only moves once btn_s has disagreed for a full counter period.
   always_comb begin
      btn_db_next = btn_db_reg;
      cnt_db_next = '0;
      if (btn_s != btn_db_reg) begin
         if (&cnt_db_reg) begin
            btn_db_next = btn_s;
         end else begin
            cnt_db_next = cnt_db_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_db_reg   <= 1'b0;
         btn_db_q_reg <= 1'b0;
         cnt_db_reg   <= '0;
      end else begin
         btn_db_reg   <= btn_db_next;
         btn_db_q_reg <= btn_db_reg;
         cnt_db_reg   <= cnt_db_next;
      end
   end

   assign level_out = btn_db_reg;
   assign press_out = btn_db_reg & ~btn_db_q_reg;

endmodule

// File: rtl/button_click_decoder.sv
// Classifies debounced KEY gestures as single or double clicks using a fixed
// window opened by the first press; results latch until rst_n.
module button_click_decoder
   import button_pkg::*;
#(
   parameter int WAIT_WIDTH     = WAIT_WIDTH_DEFAULT,
   parameter int DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   button_click_decoder_if.slave bus
);

   logic                  press;
   logic                  btn_level;
   click_state_t          state_reg;
   click_state_t          state_next;
   logic [WAIT_WIDTH-1:0] cnt_win_reg;
   logic [WAIT_WIDTH-1:0] cnt_win_next;
   logic                  single_reg;
   logic                  double_reg;

   button_debouncer #(
      .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
   ) u_debouncer (
      .clk       (clk),
      .rst_n     (rst_n),
      .button_in (bus.button),
      .level_out (btn_level),
      .press_out (press)
   );

   always_comb begin
      state_next   = state_reg;
      cnt_win_next = cnt_win_reg;
      case (state_reg)
         IDLE: begin
            if (press) begin
               state_next   = WAIT;
               cnt_win_next = '0;
            end
         end
         WAIT: begin
            // Saturate rather than wrap; a press on the final count still wins.
            if (!(&cnt_win_reg)) begin
               cnt_win_next = cnt_win_reg + 1'b1;
            end
            if (press) begin
               state_next = DOUBLE;
            end else if (&cnt_win_reg) begin
               state_next = SINGLE;
            end
         end
         default: begin
            state_next = state_reg;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_win_reg <= '0;
         single_reg  <= 1'b0;
         double_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_win_reg <= cnt_win_next;
         single_reg  <= (state_next == SINGLE);
         double_reg  <= (state_next == DOUBLE);
      end
   end

   assign bus.single = single_reg;
   assign bus.double = double_reg;

   a_press_needs_level : assert property (@(posedge clk) press |-> btn_level);
   a_outputs_exclusive : assert property (@(posedge clk) !(single_reg && double_reg));

endmodule

// File: tb/tb_button_click_decoder.sv
// Bench for button_click_decoder: segment table, boundary sweep and random
// bursts, all checked against a timestamp-based click model.
module tb_button_click_decoder;

   localparam int WW     = 4;
   localparam int DW     = 2;
   localparam int WIN    = 1 << WW;
   localparam int DB_LEN = 1 << DW;

   logic clk;
   logic rst_n;
   button_click_decoder_if bus ();

   button_click_decoder #(
      .WAIT_WIDTH     (WW),
      .DEBOUNCE_WIDTH (DW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: raw button history, debounced level, and click timestamps
   logic [31:0] rawh;
   logic        m_db;
   logic        m_dbq;
   int          m_first;
   int          m_result;   // 0 none, 1 single, 2 double
   int          m_cyc;

   typedef struct {
      logic rn;
      logic b;
      int   n;
      logic s;
      logic d;
   } seg_t;

   seg_t tbl[$];

   function automatic seg_t mk(input logic rn, input logic b, input int n,
                               input logic s, input logic d);
      seg_t r;
      r.rn = rn; r.b = b; r.n = n; r.s = s; r.d = d;
      return r;
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic rn, input logic b);
      logic p;
      logic all_diff;
      if (!rn) begin
         rawh     = '0;
         m_db     = 1'b0;
         m_dbq    = 1'b0;
         m_first  = -1;
         m_result = 0;
         m_cyc    = 0;
      end else begin
         m_cyc++;
         p = m_db & ~m_dbq;
         if (m_result == 0) begin
            if (m_first < 0) begin
               if (p) m_first = m_cyc;
            end else if (p) begin
               m_result = 2;
            end else if (m_cyc - m_first == WIN) begin
               m_result = 1;
            end
         end
         rawh = {rawh[30:0], b};
         // The debounced level flips once the last DB_LEN synchronised samples all disagree.
         all_diff = 1'b1;
         for (int i = 2; i < 2 + DB_LEN; i++) begin
            if (rawh[i] == m_db) all_diff = 1'b0;
         end
         m_dbq = m_db;
         if (all_diff) m_db = ~m_db;
      end
   endtask

   task automatic tick(input logic rn, input logic b);
      rst_n      = rn;
      bus.button = b;
      @(posedge clk);
      model_edge(rn, b);
      @(negedge clk);
      check("model_single", bus.single, m_result == 1);
      check("model_double", bus.double, m_result == 2);
   endtask

   task automatic ticks(input logic rn, input logic b, input int n);
      for (int i = 0; i < n; i++) tick(rn, b);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.button = 1'b0;
      rawh       = '0;
      m_db       = 1'b0;
      m_dbq      = 1'b0;
      m_first    = -1;
      m_result   = 0;
      m_cyc      = 0;

      // Reset with a toggling button, then idle
      tbl.push_back(mk(0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 10, 0, 0));
      // Glitch shorter than sync + debounce
      tbl.push_back(mk(1, 1, 3, 0, 0));
      tbl.push_back(mk(1, 0, 50, 0, 0));
      // Single click: press consumed at tick 7, single at tick 23
      tbl.push_back(mk(1, 1, 20, 0, 0));
      tbl.push_back(mk(1, 0, 2, 0, 0));
      tbl.push_back(mk(1, 0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 100, 1, 0));
      tbl.push_back(mk(0, 0, 3, 0, 0));
      // Double click, second press on the last window count
      tbl.push_back(mk(1, 1, 8, 0, 0));
      tbl.push_back(mk(1, 0, 8, 0, 0));
      tbl.push_back(mk(1, 1, 6, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 1));
      tbl.push_back(mk(1, 1, 1, 0, 1));
      tbl.push_back(mk(1, 0, 30, 0, 1));
      tbl.push_back(mk(0, 0, 3, 0, 0));
      // Second press one cycle too late: single, late press ignored
      tbl.push_back(mk(1, 1, 8, 0, 0));
      tbl.push_back(mk(1, 0, 9, 0, 0));
      tbl.push_back(mk(1, 1, 5, 0, 0));
      tbl.push_back(mk(1, 1, 1, 1, 0));
      tbl.push_back(mk(1, 1, 20, 1, 0));
      tbl.push_back(mk(1, 0, 20, 1, 0));
      tbl.push_back(mk(0, 0, 3, 0, 0));
      // Reset while in WAIT, then a fresh single click
      tbl.push_back(mk(1, 1, 8, 0, 0));
      tbl.push_back(mk(1, 0, 4, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 20, 0, 0));
      tbl.push_back(mk(1, 0, 2, 0, 0));
      tbl.push_back(mk(1, 0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 10, 1, 0));
      tbl.push_back(mk(0, 0, 3, 0, 0));

      @(negedge clk);
      foreach (tbl[k]) begin
         ticks(tbl[k].rn, tbl[k].b, tbl[k].n);
         check($sformatf("seg%0d_single", k), bus.single, tbl[k].s);
         check($sformatf("seg%0d_double", k), bus.double, tbl[k].d);
      end

      // Window boundary sweep: second button rise d ticks after the first
      for (int d = 14; d <= 18; d++) begin
         ticks(0, 0, 3);
         ticks(1, 1, 6);
         ticks(1, 0, d - 6);
         ticks(1, 1, 6);
         ticks(1, 0, 30);
         check($sformatf("gap%0d_double", d), bus.double, d <= WIN);
         check($sformatf("gap%0d_single", d), bus.single, d > WIN);
      end

      // Random bursts with occasional resets
      for (int r = 0; r < 200; r++) begin
         logic rn;
         logic b;
         int   n;
         rn = ($urandom_range(0, 9) != 0);
         b  = 1'($urandom_range(0, 1));
         n  = rn ? int'($urandom_range(1, 24)) : 1;
         ticks(rn, b, n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
